rambus_sample_reader: RTL

- Wishbone classic initiator on the user-project side of the shared rambus.
- Sequentially reads a window of 32-bit words from the 1 kB dual-port OpenRAM, wrapping around the window for as long as it is enabled.
- Buffers the words in a small FIFO and presents them as a valid/ready sample stream, for waveform playback by the function generator.
- Talks only to port B of the OpenRAM wishbone wrapper and never writes.

---
 rtl/rambus_sample_reader_if.sv | 26 ++
 rtl/rambus_sample_reader.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/rambus_sample_reader_if.sv
// Wishbone classic bus between the sample reader (master) and port B of the
// OpenRAM wishbone wrapper (slave).
interface rambus_sample_reader_if;
    logic        wb_clk_o;
    logic        wb_rst_o;
    logic        wb_stb_o;
    logic        wb_cyc_o;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_o;
    logic [9:0]  wb_adr_o;
    logic        wb_ack_i;
    logic [31:0] wb_dat_i;

    modport master (
        output wb_clk_o, wb_rst_o, wb_stb_o, wb_cyc_o, wb_we_o,
               wb_sel_o, wb_dat_o, wb_adr_o,
        input  wb_ack_i, wb_dat_i
    );

    modport slave (
        input  wb_clk_o, wb_rst_o, wb_stb_o, wb_cyc_o, wb_we_o,
               wb_sel_o, wb_dat_o, wb_adr_o,
        output wb_ack_i, wb_dat_i
    );
endinterface

// File: rtl/rambus_sample_reader.sv
// Read-only wishbone initiator that loops over a word window of the OpenRAM and
// streams the words out through a small FWFT FIFO. Ack timeout: RAMBUS_READER_TIMEOUT_EN.
module rambus_sample_reader #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic                   enable,
    input  logic [7:0]             start_addr,
    input  logic [7:0]             end_addr,
    output logic [31:0]            sample_o,
    output logic                   sample_valid_o,
    input  logic                   sample_ready_i,
    output logic                   busy_o,
    output logic                   error_o,
    rambus_sample_reader_if.master rambus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    logic [1:0]    state_reg, state_next;
    logic [7:0]    ptr_reg, win_start_reg, win_end_reg;
    logic [31:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic          push, pop, flush, room, timeout, ack;

    assign ack            = rambus.wb_ack_i;
    assign sample_valid_o = (count_reg != '0);
    assign pop            = sample_valid_o && sample_ready_i;
    // A pop in the same cycle frees the slot the next read will land in.
    assign room           = (count_reg < DEPTH_C) || pop;
    assign sample_o       = sample_valid_o ? fifo_mem[rd_ptr_reg] : 32'd0;
    assign busy_o         = (state_reg != ST_IDLE);

    assign rambus.wb_clk_o = wb_clk_i;
    assign rambus.wb_rst_o = wb_rst_i;
    assign rambus.wb_cyc_o = (state_reg == ST_REQ) && !wb_rst_i;
    assign rambus.wb_stb_o = (state_reg == ST_REQ) && !wb_rst_i;
    assign rambus.wb_we_o  = 1'b0;
    assign rambus.wb_sel_o = 4'hF;
    assign rambus.wb_dat_o = 32'd0;
    assign rambus.wb_adr_o = {ptr_reg, 2'b00};

    always_comb begin
        state_next = state_reg;
        push       = 1'b0;
        flush      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                flush = 1'b1;
                if (enable && !error_o) state_next = ST_REQ;
            end
            ST_REQ: begin
                if (ack) begin
                    // A word acked after enable fell is dropped, not queued.
                    push       = enable;
                    flush      = !enable;
                    state_next = enable ? ST_GAP : ST_IDLE;
                end else if (timeout) begin
                    flush      = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (!enable) begin
                    flush      = 1'b1;
                    state_next = ST_IDLE;
                end else if (room) begin
                    state_next = ST_REQ;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_reg     <= ST_IDLE;
            ptr_reg       <= 8'd0;
            win_start_reg <= 8'd0;
            win_end_reg   <= 8'd0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_IDLE && state_next == ST_REQ) begin
                ptr_reg       <= start_addr;
                win_start_reg <= start_addr;
                win_end_reg   <= end_addr;
            end else if (state_reg == ST_REQ && ack) begin
                ptr_reg <= (ptr_reg == win_end_reg) ? win_start_reg : ptr_reg + 8'd1;
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (push) fifo_mem[wr_ptr_reg] <= rambus.wb_dat_i;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

`ifdef RAMBUS_READER_TIMEOUT_EN
    localparam int TW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [TW-1:0] tmo_cnt_reg;
    logic          error_reg;

    // Counter holds the number of REQ cycles already spent without an ack.
    assign timeout = (state_reg == ST_REQ) && (tmo_cnt_reg == TW'(TIMEOUT_CYCLES - 1));
    assign error_o = error_reg;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            tmo_cnt_reg <= '0;
            error_reg   <= 1'b0;
        end else begin
            if (state_reg == ST_REQ && !ack && !timeout) tmo_cnt_reg <= tmo_cnt_reg + TW'(1);
            else                                         tmo_cnt_reg <= '0;
            if (state_reg == ST_REQ && !ack && timeout) error_reg <= 1'b1;
            else if (!enable)                           error_reg <= 1'b0;
        end
    end
`else
    assign timeout = 1'b0;
    // Without the timeout build the reader waits for ack forever and never flags an error.
    if (TIMEOUT_CYCLES > 0) begin : g_no_timeout
        assign error_o = 1'b0;
    end else begin : g_no_timeout_zero
        assign error_o = 1'b0;
    end
`endif
endmodule
